// File: rtl/led_scan_if.sv
// Host/display bundle for the LED scan controller: write port, commit and
// display configuration in, scanned digit stream and status out.
interface led_scan_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic       commit;
  logic [2:0] bright;
  logic       lz_en;
  logic [7:0] dig_sel;
  logic [3:0] dig_val;
  logic       dig_dp;
  logic       commit_pend;
  logic       frame_tick;

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_dp, commit, bright, lz_en,
    output dig_sel, dig_val, dig_dp, commit_pend, frame_tick
  );

  modport master (
    output wr_en, wr_addr, wr_data, wr_dp, commit, bright, lz_en,
    input  dig_sel, dig_val, dig_dp, commit_pend, frame_tick
  );
endinterface

// File: rtl/led_scan_ctrl.sv
// 8-digit seven-segment scan controller: slot/digit timing, double-buffered
// digit memory, dead time, 8-level brightness and leading-zero blanking.
module led_scan_ctrl #(
  parameter int SLOT_CYC  = 6250,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  led_scan_if.slave  io_bus
);

  localparam int            CW       = $clog2(SLOT_CYC + 1);
  localparam logic [CW-1:0] ZERO_L   = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_L    = CW'(1);
  localparam logic [CW-1:0] LAST_L   = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] PRELAST_L = CW'(SLOT_CYC - 2);
  localparam logic [CW-1:0] BLANK_L  = CW'(BLANK_CYC);
  localparam logic [CW-1:0] STEP_L   = CW'((SLOT_CYC - BLANK_CYC) >> 3);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    r_idx;
  logic [2:0]    w_idx_nxt;
  logic [2:0]    r_bright;
  logic [2:0]    w_bright;
  logic [CW-1:0] w_on_end;
  logic          w_on;
  logic [4:0]    r_shadow [8];
  logic [4:0]    r_active [8];
  logic [4:0]    w_act_nxt [8];
  logic          w_copy;
  logic [7:0]    w_zero;
  logic [7:0]    w_lz_blank;
  logic [7:0]    w_sel_nxt;
  logic          r_frame_tick;
  logic          r_commit_pend;
  logic [7:0]    r_dig_sel;
  logic [3:0]    r_dig_val;
  logic          r_dig_dp;

  always_comb begin
    if (r_cnt == LAST_L) begin
      w_cnt_nxt = ZERO_L;
      w_idx_nxt = r_idx + 3'd1;
    end else begin
      w_cnt_nxt = r_cnt + ONE_L;
      w_idx_nxt = r_idx;
    end
  end

  // Brightness is taken live during count 0 and held for the rest of the slot.
  always_comb begin
    if (r_cnt == ZERO_L) begin
      w_bright = io_bus.bright;
    end else begin
      w_bright = r_bright;
    end
    w_on_end = BLANK_L + STEP_L * CW'(w_bright) + STEP_L;
  end

  // Contents the active buffer will hold next cycle, so the outputs and the
  // blanking mask already reflect a commit on the first cycle of the frame.
  always_comb begin
    w_copy = r_frame_tick & r_commit_pend;
    for (int i = 0; i < 8; i++) begin
      w_act_nxt[i] = w_copy ? r_shadow[i] : r_active[i];
      w_zero[i]    = (w_act_nxt[i] == 5'd0);
    end
  end

  // Digit i is blanked when it and every digit above it are zero without dp.
  always_comb begin
    w_lz_blank = 8'h00;
    for (int i = 1; i < 8; i++) begin
      w_lz_blank[i] = 1'b1;
      for (int j = i; j < 8; j++) begin
        w_lz_blank[i] = w_lz_blank[i] & w_zero[j];
      end
    end
  end

  always_comb begin
    w_on = (w_cnt_nxt >= BLANK_L) && (w_cnt_nxt < w_on_end) &&
           !(io_bus.lz_en && w_lz_blank[w_idx_nxt]);
    for (int i = 0; i < 8; i++) begin
      w_sel_nxt[i] = !(w_on && (w_idx_nxt == 3'(i)));
    end
  end

  // Scan timing and the per-slot brightness latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= ZERO_L;
      r_idx        <= 3'd0;
      r_bright     <= 3'd0;
      r_frame_tick <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_bright     <= w_bright;
      r_frame_tick <= (r_cnt == PRELAST_L) && (r_idx == 3'd7);
    end
  end

  // Shadow/active buffers; the snapshot uses shadow before this cycle's write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_shadow[i] <= 5'd0;
        r_active[i] <= 5'd0;
      end
      r_commit_pend <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        r_active[i] <= w_act_nxt[i];
      end
      if (io_bus.wr_en) begin
        r_shadow[io_bus.wr_addr] <= {io_bus.wr_dp, io_bus.wr_data};
      end
      if (w_copy) begin
        r_commit_pend <= 1'b0;
      end else if (io_bus.commit) begin
        r_commit_pend <= 1'b1;
      end else begin
        r_commit_pend <= r_commit_pend;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dig_sel <= 8'hFF;
      r_dig_val <= 4'd0;
      r_dig_dp  <= 1'b0;
    end else begin
      r_dig_sel <= w_sel_nxt;
      r_dig_val <= w_act_nxt[w_idx_nxt][3:0];
      r_dig_dp  <= w_act_nxt[w_idx_nxt][4];
    end
  end

  assign io_bus.dig_sel     = r_dig_sel;
  assign io_bus.dig_val     = r_dig_val;
  assign io_bus.dig_dp      = r_dig_dp;
  assign io_bus.commit_pend = r_commit_pend;
  assign io_bus.frame_tick  = r_frame_tick;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl with a short slot (40 cycles, 4 dead time):
// timing, commit, brightness, leading-zero blanking and mid-scan reset.
module tb_led_scan_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   t;

  led_scan_if bus ();

  led_scan_ctrl #(.SLOT_CYC(40), .BLANK_CYC(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // t counts rising edges since reset release; sampling happens on falling edges.
  task automatic goto(input int target);
    while (t < target) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d, input logic dp);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_dp = dp;
    @(negedge clk); t++;
    bus.wr_en = 1'b0;
  endtask

  task automatic do_commit();
    bus.commit = 1'b1;
    @(negedge clk); t++;
    bus.commit = 1'b0;
  endtask

  task automatic check_slot(input string tag, input int base, input int d, input int on_len,
                            input logic lit, input logic [3:0] v, input logic dp);
    logic [7:0] on_v;
    on_v = 8'hFF;
    if (lit) on_v[d] = 1'b0;
    goto(base + 3);
    chk($sformatf("%s d%0d pre", tag, d), bus.dig_sel, 8'hFF);
    chk($sformatf("%s d%0d val", tag, d), {4'd0, bus.dig_val}, {4'd0, v});
    chk($sformatf("%s d%0d dp", tag, d), {7'd0, bus.dig_dp}, {7'd0, dp});
    goto(base + 4);
    chk($sformatf("%s d%0d first_on", tag, d), bus.dig_sel, on_v);
    goto(base + 3 + on_len);
    chk($sformatf("%s d%0d last_on", tag, d), bus.dig_sel, on_v);
    goto(base + 4 + on_len);
    chk($sformatf("%s d%0d off", tag, d), bus.dig_sel, 8'hFF);
  endtask

  task automatic check_frame(input string tag, input int fbase, input int d_first, input int on_len,
                             input logic [7:0] lit, input logic [31:0] vals, input logic [7:0] dps);
    for (int d = d_first; d < 8; d++) begin
      check_slot(tag, fbase + 40 * d, d, on_len, lit[d], vals[4*d +: 4], dps[d]);
    end
  endtask

  task automatic chk_status(input string tag, input logic tick, input logic pend);
    chk({tag, " tick"}, {7'd0, bus.frame_tick}, {7'd0, tick});
    chk({tag, " pend"}, {7'd0, bus.commit_pend}, {7'd0, pend});
  endtask

  initial begin
    checks = 0; errors = 0; t = 0;
    rst_n = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = 3'd0; bus.wr_data = 4'd0; bus.wr_dp = 1'b0;
    bus.commit = 1'b0; bus.bright = 3'd7; bus.lz_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst sel", bus.dig_sel, 8'hFF);
    chk("rst val", {4'd0, bus.dig_val}, 8'h00);
    chk("rst dp", {7'd0, bus.dig_dp}, 8'h00);
    chk_status("rst", 1'b0, 1'b0);
    rst_n = 1'b1;
    t = 0;

    // Idle scan, full brightness, frame tick placement.
    check_frame("idle", 0, 0, 32, 8'hFF, 32'h0, 8'h00);
    goto(318); chk_status("f0 318", 1'b0, 1'b0);
    goto(319); chk_status("f0 319", 1'b1, 1'b0);
    goto(320); chk_status("f0 320", 1'b0, 1'b0);

    // Load 1..8 with dp on digit 3, commit mid-frame.
    goto(322);
    for (int i = 0; i < 8; i++) wr(3'(i), 4'(i + 1), (i == 3) ? 1'b1 : 1'b0);
    do_commit();
    chk_status("commit", 1'b0, 1'b1);
    check_frame("old", 320, 1, 32, 8'hFF, 32'h0, 8'h00);
    goto(639); chk_status("f1 end", 1'b1, 1'b1);
    goto(640); chk_status("f2 start", 1'b0, 1'b0);
    check_frame("new", 640, 0, 32, 8'hFF, 32'h87654321, 8'h08);

    // Writes without a commit never reach the display.
    goto(965);
    for (int i = 0; i < 8; i++) wr(3'(i), 4'd9, 1'b1);
    chk_status("nocommit", 1'b0, 1'b0);
    goto(1279); chk_status("f3 end", 1'b1, 1'b0);
    check_frame("hold4", 1280, 0, 32, 8'hFF, 32'h87654321, 8'h08);
    goto(1599); chk_status("f4 end", 1'b1, 1'b0);
    check_frame("hold5", 1600, 0, 32, 8'hFF, 32'h87654321, 8'h08);

    // Brightness 0, then 3 applied mid-slot, then back to 7.
    goto(1917); bus.bright = 3'd0;
    goto(1919); chk_status("f5 end", 1'b1, 1'b0);
    check_slot("br0", 1920, 0, 4, 1'b1, 4'd1, 1'b0);
    goto(1930); bus.bright = 3'd3;
    goto(1950); chk("br0 late", bus.dig_sel, 8'hFF);
    check_slot("br3", 1960, 1, 16, 1'b1, 4'd2, 1'b0);
    goto(1985); bus.bright = 3'd7;
    check_slot("br7", 2000, 2, 32, 1'b1, 4'd3, 1'b0);

    // Leading-zero blanking on 00000305.
    goto(2245);
    wr(3'd0, 4'd5, 1'b0); wr(3'd1, 4'd0, 1'b0); wr(3'd2, 4'd3, 1'b0);
    for (int i = 3; i < 8; i++) wr(3'(i), 4'd0, 1'b0);
    do_commit();
    chk_status("lz commit", 1'b0, 1'b1);
    goto(2555); bus.lz_en = 1'b1;
    check_frame("lz305", 2560, 0, 32, 8'h07, 32'h00000305, 8'h00);

    // All zeros; a write on the copy cycle stays out of the snapshot.
    goto(2880);
    for (int i = 0; i < 8; i++) wr(3'(i), 4'd0, 1'b0);
    do_commit();
    chk_status("zero commit", 1'b0, 1'b1);
    goto(3199); chk_status("f9 end", 1'b1, 1'b1);
    wr(3'd7, 4'd4, 1'b0);
    chk_status("f10 start", 1'b0, 1'b0);
    check_frame("lz0", 3200, 0, 32, 8'h01, 32'h0, 8'h00);

    // Commit on the frame_tick cycle with nothing pending: applied one frame later.
    goto(3519); chk_status("f10 end", 1'b1, 1'b0);
    do_commit();
    chk_status("late commit", 1'b0, 1'b1);
    check_frame("lz0b", 3520, 0, 32, 8'h01, 32'h0, 8'h00);
    goto(3839); chk_status("f11 end", 1'b1, 1'b1);
    goto(3840); chk_status("f12 start", 1'b0, 1'b0);
    check_frame("d7", 3840, 0, 32, 8'hFF, 32'h40000000, 8'h00);

    // Reset in the ON phase of digit 5.
    goto(4370);
    chk("pre reset sel", bus.dig_sel, 8'hDF);
    rst_n = 1'b0;
    #1;
    chk("async sel", bus.dig_sel, 8'hFF);
    chk("async val", {4'd0, bus.dig_val}, 8'h00);
    chk_status("async", 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    check_slot("post", 0, 0, 32, 1'b1, 4'd0, 1'b0);
    check_slot("post", 280, 7, 32, 1'b0, 4'd0, 1'b0);
    goto(319); chk_status("post end", 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
